gyro_hsi_scan_ctrl: RTL and testbench

Round-robin scan sequencer for up to 8 gyro serial channels sharing one SDI/SCLK pair.
- Walks an enabled-channel mask and drives one chip-select at a time, with programmable polarity.
- Generates SCLK at a programmable half-period and shifts in a 16-bit sample per channel, MSB first.
- Presents each sample with its channel number to the AXI register block.

---
 rtl/gyro_hsi_scan_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_gyro_hsi_scan_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gyro_hsi_scan_ctrl.sv
// Round-robin scan sequencer for up to eight gyro serial channels sharing one SDI/SCLK pair.
// Each enabled channel gets a chip-select window and a 16-bit MSB-first frame.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start with a non-empty mask
// SELECT   | CS active, sclk low for one half period
// SHIFT    | sclk running, sdi captured on every rising sclk edge
// DESELECT | CS released, sample presented, one half period of rest
// GAP      | inter-round idle time in continuous mode
module gyro_hsi_scan_ctrl #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              continuous,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              cs_pol,
    input  logic [7:0]        half_period,
    input  logic [15:0]       gap,
    input  logic              sdi,
    output logic              sclk,
    output logic [NUM_CH-1:0] cs_out,
    output logic              busy,
    output logic              sample_valid,
    output logic [DATA_W-1:0] sample_data,
    output logic [2:0]        sample_ch,
    output logic              frame_done
);

    localparam int TW = $clog2(2 * DATA_W + 1);

    typedef enum logic [2:0] {IDLE, SELECT, SHIFT, DESELECT, GAP} state_t;

    state_t              state_q, state_d;
    logic [2:0]          ch_q, ch_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [NUM_CH-1:0]   onehot_q, onehot_d;
    logic [7:0]          h_q, h_d;
    logic                pol_q, pol_d;
    logic [15:0]         gap_q, gap_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [TW-1:0]       tog_q, tog_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                sclk_q, sclk_d;
    logic [DATA_W-1:0]   sdata_q, sdata_d;
    logic [2:0]          sch_q, sch_d;
    logic                svalid_q, svalid_d;
    logic                fdone_q, fdone_d;

    logic [7:0]          h_eff;
    logic [15:0]         h_eff_m1;
    logic [15:0]         hm1;
    logic [3:0]          first;
    logic [3:0]          nxt;
    logic                restart;

    // Returns {found, index} of the lowest set bit at or above lo.
    function automatic logic [3:0] pick(input logic [NUM_CH-1:0] m, input int lo);
        logic [3:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i] && i >= lo) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    assign h_eff    = (half_period == 8'd0) ? 8'd1 : half_period;
    assign h_eff_m1 = {8'd0, h_eff} - 16'd1;
    assign hm1      = {8'd0, h_q} - 16'd1;
    assign first    = pick(ch_mask, 0);
    assign nxt      = pick(mask_q, int'(ch_q) + 1);

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        mask_d   = mask_q;
        onehot_d = onehot_q;
        h_d      = h_q;
        pol_d    = pol_q;
        gap_d    = gap_q;
        cnt_d    = cnt_q;
        tog_d    = tog_q;
        shreg_d  = shreg_q;
        sclk_d   = sclk_q;
        sdata_d  = sdata_q;
        sch_d    = sch_q;
        svalid_d = 1'b0;
        fdone_d  = 1'b0;
        restart  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && first[3]) restart = 1'b1;
            end
            SELECT: begin
                if (cnt_q == 16'd0) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b1;
                    shreg_d = {shreg_q[DATA_W-2:0], sdi};
                    tog_d   = TW'(1);
                    cnt_d   = hm1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            SHIFT: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (tog_q == TW'(2 * DATA_W)) begin
                    state_d  = DESELECT;
                    onehot_d = '0;
                    sdata_d  = shreg_q;
                    sch_d    = ch_q;
                    svalid_d = 1'b1;
                    cnt_d    = hm1;
                end else begin
                    sclk_d = ~sclk_q;
                    if (!sclk_q) shreg_d = {shreg_q[DATA_W-2:0], sdi};
                    tog_d  = tog_q + TW'(1);
                    cnt_d  = hm1;
                end
            end
            DESELECT: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (nxt[3]) begin
                    state_d  = SELECT;
                    ch_d     = nxt[2:0];
                    onehot_d = {{(NUM_CH-1){1'b0}}, 1'b1} << nxt[2:0];
                    cnt_d    = hm1;
                end else begin
                    fdone_d = 1'b1;
                    if (!continuous) begin
                        state_d = IDLE;
                    end else if (gap_q == 16'd0) begin
                        restart = 1'b1;
                    end else begin
                        state_d = GAP;
                        cnt_d   = gap_q - 16'd1;
                    end
                end
            end
            GAP: begin
                if (cnt_q == 16'd0) restart = 1'b1;
                else cnt_d = cnt_q - 16'd1;
            end
            default: state_d = IDLE;
        endcase

        // A round (re)start snapshots the configuration so later input changes cannot disturb it.
        if (restart) begin
            mask_d = ch_mask;
            h_d    = h_eff;
            pol_d  = cs_pol;
            gap_d  = gap;
            sclk_d = 1'b0;
            if (first[3]) begin
                state_d  = SELECT;
                ch_d     = first[2:0];
                onehot_d = {{(NUM_CH-1){1'b0}}, 1'b1} << first[2:0];
                cnt_d    = h_eff_m1;
            end else begin
                state_d = IDLE;
            end
        end

        if (abort && state_q != IDLE) begin
            state_d  = IDLE;
            sclk_d   = 1'b0;
            onehot_d = '0;
            sdata_d  = sdata_q;
            sch_d    = sch_q;
            svalid_d = 1'b0;
            fdone_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            mask_q   <= '0;
            onehot_q <= '0;
            h_q      <= 8'd1;
            pol_q    <= 1'b0;
            gap_q    <= '0;
            cnt_q    <= '0;
            tog_q    <= '0;
            shreg_q  <= '0;
            sclk_q   <= 1'b0;
            sdata_q  <= '0;
            sch_q    <= '0;
            svalid_q <= 1'b0;
            fdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            mask_q   <= mask_d;
            onehot_q <= onehot_d;
            h_q      <= h_d;
            pol_q    <= pol_d;
            gap_q    <= gap_d;
            cnt_q    <= cnt_d;
            tog_q    <= tog_d;
            shreg_q  <= shreg_d;
            sclk_q   <= sclk_d;
            sdata_q  <= sdata_d;
            sch_q    <= sch_d;
            svalid_q <= svalid_d;
            fdone_q  <= fdone_d;
        end
    end

    assign sclk         = sclk_q;
    assign cs_out       = onehot_q ^ {NUM_CH{pol_q}};
    assign busy         = (state_q != IDLE);
    assign sample_valid = svalid_q;
    assign sample_data  = sdata_q;
    assign sample_ch    = sch_q;
    assign frame_done   = fdone_q;

endmodule

// File: tb/tb_gyro_hsi_scan_ctrl.sv
// Self-checking bench for gyro_hsi_scan_ctrl: a gyro model drives sdi per channel,
// a scoreboard queue holds the samples each scan is expected to produce.
module tb_gyro_hsi_scan_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        continuous = 1'b0;
    logic [7:0]  ch_mask = 8'h00;
    logic        cs_pol = 1'b0;
    logic [7:0]  half_period = 8'd1;
    logic [15:0] gap = 16'd0;
    logic        sdi = 1'b0;
    logic        sclk;
    logic [7:0]  cs_out;
    logic        busy;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic [2:0]  sample_ch;
    logic        frame_done;

    gyro_hsi_scan_ctrl dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .continuous(continuous), .ch_mask(ch_mask), .cs_pol(cs_pol),
        .half_period(half_period), .gap(gap), .sdi(sdi), .sclk(sclk),
        .cs_out(cs_out), .busy(busy), .sample_valid(sample_valid),
        .sample_data(sample_data), .sample_ch(sample_ch), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  ch;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] word [8];
    logic        tb_pol = 1'b0;

    // Observation results of the most recent round
    int          k_end, n_rise, n_sv, n_fd, first_rise, second_rise, sv_k, fd_k, fd2_k, gap_idle;
    bit          timed_out;
    logic [7:0]  cs_seq[$];

    // Gyro model: restarts at MSB when a new CS window opens, advances after each sclk rise
    logic [7:0]  drv_last = 8'h00;
    logic [7:0]  act;
    logic        drv_prev = 1'b0;
    int          bidx = 15;
    int          cur = 0;
    always @(negedge clock) begin
        act = cs_out ^ {8{tb_pol}};
        if (act != drv_last) begin
            if ($onehot(act)) begin
                for (int i = 0; i < 8; i++) if (act[i]) cur = i;
                bidx = 15;
                sdi  = word[cur][15];
            end
        end else if (sclk && !drv_prev && bidx > 0) begin
            bidx = bidx - 1;
            sdi  = word[cur][bidx];
        end
        drv_last = act;
        drv_prev = sclk;
    end

    // Scoreboard consumer
    always @(negedge clock) begin
        if (reset_n && sample_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got ch=%0d data=%h, required no sample", sample_ch, sample_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (sample_ch !== e.ch || sample_data !== e.data) begin
                    errors++;
                    $display("FAIL sb_sample: got ch=%0d data=%h, required ch=%0d data=%h",
                             sample_ch, sample_data, e.ch, e.data);
                end
            end
        end
    end

    task automatic cfg(input logic [7:0] m, input logic [7:0] hp, input logic pol,
                       input logic cont, input logic [15:0] g);
        ch_mask = m; half_period = hp; cs_pol = pol; continuous = cont; gap = g; tb_pol = pol;
    endtask

    task automatic push(input logic [2:0] ch, input logic [15:0] d);
        exp_t e;
        e.ch = ch; e.data = d;
        sb.push_back(e);
    endtask

    task automatic pulse_start();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    // Collects per-cycle statistics from the cycle after start acceptance (k=0) until busy drops.
    task automatic observe(input int max_cyc, input int clear_k, input int abort_rise, input int poke_k);
        int k;
        logic prev_sclk;
        logic [7:0] last_cs;
        logic [7:0] idle_cs;
        bit counting;
        idle_cs = {8{tb_pol}};
        k = 0; prev_sclk = 1'b0; last_cs = idle_cs; counting = 0;
        n_rise = 0; n_sv = 0; n_fd = 0; first_rise = -1; second_rise = -1;
        sv_k = -1; fd_k = -1; fd2_k = -1; gap_idle = 0; timed_out = 0;
        cs_seq.delete();
        forever begin
            if (abort) abort = 1'b0;
            if (k == clear_k) continuous = 1'b0;
            if (k == poke_k) begin
                start = 1'b1; ch_mask = 8'hFF; half_period = 8'd5; cs_pol = ~cs_pol;
            end else if (poke_k >= 0 && k == poke_k + 1) begin
                start = 1'b0;
            end
            if (sclk && !prev_sclk) begin
                n_rise++;
                if (first_rise < 0) first_rise = k;
                else if (second_rise < 0) second_rise = k;
                if (n_rise == abort_rise) abort = 1'b1;
            end
            if (sample_valid) begin
                n_sv++;
                if (sv_k < 0) sv_k = k;
            end
            if (frame_done) begin
                n_fd++;
                if (fd_k < 0) begin fd_k = k; counting = 1; end
                else fd2_k = k;
            end
            if (counting) begin
                if (cs_out == idle_cs && !sclk) gap_idle++;
                else counting = 0;
            end
            if (cs_out != last_cs) begin
                cs_seq.push_back(cs_out);
                last_cs = cs_out;
            end
            prev_sclk = sclk;
            if (!busy) break;
            if (k >= max_cyc) begin timed_out = 1; break; end
            @(negedge clock);
            k++;
        end
        k_end = k;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #3 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({sclk, busy, sample_valid, frame_done} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b, required 0000", {sclk, busy, sample_valid, frame_done});
        end
        checks++;
        if (cs_out !== 8'h00) begin errors++; $display("FAIL reset_cs: got %h, required 00", cs_out); end
        checks++;
        if (sample_data !== 16'h0 || sample_ch !== 3'd0) begin
            errors++; $display("FAIL reset_sample: got %h/%0d, required 0000/0", sample_data, sample_ch);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_two_channel();
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'hFE; exp_seq[1] = 8'hFF; exp_seq[2] = 8'hFB; exp_seq[3] = 8'hFF;
        cfg(8'h05, 8'd2, 1'b1, 1'b0, 16'd0);
        push(3'd0, word[0]); push(3'd2, word[2]);
        pulse_start();
        observe(400, -1, -1, -1);
        checks++;
        if (timed_out) begin errors++; $display("FAIL two_ch_timeout: got busy after %0d cycles, required idle", k_end); end
        checks++;
        if (cs_seq.size() != 4) begin
            errors++; $display("FAIL two_ch_cs_len: got %0d, required 4", cs_seq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (cs_seq[i] !== exp_seq[i]) begin
                    errors++; $display("FAIL two_ch_cs[%0d]: got %h, required %h", i, cs_seq[i], exp_seq[i]);
                end
            end
        end
        checks++;
        if (first_rise != 2 || second_rise - first_rise != 4) begin
            errors++; $display("FAIL two_ch_sclk: got rise %0d period %0d, required 2 and 4", first_rise, second_rise - first_rise);
        end
        checks++;
        if (n_rise != 32) begin errors++; $display("FAIL two_ch_rises: got %0d, required 32", n_rise); end
        checks++;
        if (sv_k != 66 || n_sv != 2) begin
            errors++; $display("FAIL two_ch_valid: got k=%0d n=%0d, required k=66 n=2", sv_k, n_sv);
        end
        checks++;
        if (n_fd != 1 || fd_k != 136 || k_end != 136) begin
            errors++; $display("FAIL two_ch_done: got n=%0d k=%0d end=%0d, required 1/136/136", n_fd, fd_k, k_end);
        end
    endtask

    task automatic test_min_half();
        cfg(8'h80, 8'd0, 1'b0, 1'b0, 16'd0);
        push(3'd7, word[7]);
        pulse_start();
        observe(200, -1, -1, -1);
        checks++;
        if (cs_seq.size() < 1 || cs_seq[0] !== 8'h80) begin
            errors++; $display("FAIL min_half_cs: got %h, required 80", cs_seq.size() > 0 ? cs_seq[0] : 8'hxx);
        end
        checks++;
        if (first_rise != 1 || second_rise - first_rise != 2) begin
            errors++; $display("FAIL min_half_sclk: got rise %0d period %0d, required 1 and 2", first_rise, second_rise - first_rise);
        end
        checks++;
        if (sv_k != 33 || fd_k != 34 || n_fd != 1) begin
            errors++; $display("FAIL min_half_timing: got valid %0d done %0d n=%0d, required 33/34/1", sv_k, fd_k, n_fd);
        end
    endtask

    task automatic test_continuous();
        cfg(8'h03, 8'd1, 1'b0, 1'b1, 16'd10);
        push(3'd0, word[0]); push(3'd1, word[1]); push(3'd0, word[0]); push(3'd1, word[1]);
        pulse_start();
        observe(400, 90, -1, -1);
        checks++;
        if (gap_idle != 10) begin errors++; $display("FAIL cont_gap: got %0d idle cycles, required 10", gap_idle); end
        checks++;
        if (n_sv != 4 || n_fd != 2) begin
            errors++; $display("FAIL cont_counts: got sv=%0d fd=%0d, required 4/2", n_sv, n_fd);
        end
        checks++;
        if (fd_k != 68 || fd2_k != 146 || k_end != 146) begin
            errors++; $display("FAIL cont_timing: got %0d/%0d end %0d, required 68/146/146", fd_k, fd2_k, k_end);
        end
    endtask

    task automatic test_abort();
        bit stayed;
        cfg(8'h05, 8'd2, 1'b1, 1'b0, 16'd0);
        pulse_start();
        observe(400, -1, 8, -1);
        checks++;
        if (k_end != 31 || n_rise != 8) begin
            errors++; $display("FAIL abort_idle: got end %0d rises %0d, required 31/8", k_end, n_rise);
        end
        checks++;
        if (cs_out !== 8'hFF || sclk !== 1'b0) begin
            errors++; $display("FAIL abort_outputs: got cs=%h sclk=%b, required FF/0", cs_out, sclk);
        end
        checks++;
        if (n_sv != 0 || n_fd != 0) begin
            errors++; $display("FAIL abort_pulses: got sv=%0d fd=%0d, required 0/0", n_sv, n_fd);
        end
        ch_mask = 8'h00;
        pulse_start();
        stayed = 1;
        for (int i = 0; i < 5; i++) begin
            if (busy !== 1'b0 || cs_out !== 8'hFF) stayed = 0;
            @(negedge clock);
        end
        checks++;
        if (!stayed) begin errors++; $display("FAIL empty_mask: got busy=%b cs=%h, required 0/FF", busy, cs_out); end
    endtask

    task automatic test_reset_mid();
        cfg(8'h05, 8'd1, 1'b1, 1'b0, 16'd0);
        pulse_start();
        repeat (10) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({sclk, busy, sample_valid, frame_done} !== 4'b0000 || cs_out !== 8'h00) begin
            errors++; $display("FAIL reset_mid: got %b cs=%h, required 0000/00", {sclk, busy, sample_valid, frame_done}, cs_out);
        end
        checks++;
        if (sample_data !== 16'h0 || sample_ch !== 3'd0) begin
            errors++; $display("FAIL reset_mid_sample: got %h/%0d, required 0000/0", sample_data, sample_ch);
        end
        @(negedge clock);
        reset_n = 1'b1;
        push(3'd0, word[0]); push(3'd2, word[2]);
        pulse_start();
        observe(200, -1, -1, -1);
        checks++;
        if (n_sv != 2 || n_fd != 1 || sv_k != 33 || timed_out) begin
            errors++; $display("FAIL reset_mid_rescan: got sv=%0d fd=%0d k=%0d, required 2/1/33", n_sv, n_fd, sv_k);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'h01; exp_seq[1] = 8'h00; exp_seq[2] = 8'h04; exp_seq[3] = 8'h00;
        cfg(8'h05, 8'd2, 1'b0, 1'b0, 16'd0);
        push(3'd0, word[0]); push(3'd2, word[2]);
        pulse_start();
        observe(400, -1, -1, 20);
        checks++;
        if (first_rise != 2 || second_rise - first_rise != 4 || sv_k != 66 || fd_k != 136 || k_end != 136) begin
            errors++; $display("FAIL b2b_timing: got %0d/%0d/%0d/%0d/%0d, required 2/4/66/136/136",
                               first_rise, second_rise - first_rise, sv_k, fd_k, k_end);
        end
        checks++;
        if (cs_seq.size() != 4) begin
            errors++; $display("FAIL b2b_cs_len: got %0d, required 4", cs_seq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (cs_seq[i] !== exp_seq[i]) begin
                    errors++; $display("FAIL b2b_cs[%0d]: got %h, required %h", i, cs_seq[i], exp_seq[i]);
                end
            end
        end
        checks++;
        if (n_sv != 2 || n_fd != 1 || n_rise != 32) begin
            errors++; $display("FAIL b2b_counts: got sv=%0d fd=%0d rises=%0d, required 2/1/32", n_sv, n_fd, n_rise);
        end
    endtask

    initial begin
        word[0] = 16'hA5C3; word[1] = 16'h0F0F; word[2] = 16'h1234; word[3] = 16'h5555;
        word[4] = 16'hAAAA; word[5] = 16'h8001; word[6] = 16'h7FFE; word[7] = 16'h6DB9;
        test_reset();
        test_two_channel();
        test_min_half();
        test_continuous();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending, required 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
